// File: rtl/simd_alu_pipe_pkg.sv
// Shared types for the SIMD ALU pipeline: opcode encoding and lane slicing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simd_pkg;

    localparam int OPCODE_W = 3;

    // Codes 110/111 are reserved; the lanes treat them as a zero-result pass-through.
    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_MUL     = 3'b010,
        OP_MULH    = 3'b011,
        OP_MAC     = 3'b100,
        OP_ACC_CLR = 3'b101
    } simd_op_e;

    // Bit offset of lane 'lane' inside a packed LANES*width bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/simd_alu_pipe_lane.sv
// One SIMD lane: the S2 compute stage (add/sub/mul/mulh/mac/clr) plus its accumulator.
// Latency: one cycle; result and overflow are registered when en is high.
// Backpressure: en is the stage enable; with en low the result, overflow and acc all hold.
//
// Ports: clk, rst_n (async active-low), en, op, a, b -> res, ovf.
// Build option: define SIMD_ALU_SAT_EN to saturate ADD/SUB/MUL results and the MAC
// accumulator instead of wrapping; overflow is reported the same way in both builds.
module simd_lane
    import simd_pkg::*;
#(
    parameter int OW    = 32,
    parameter int ACC_W = 2 * OW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [OPCODE_W-1:0] op,
    input  logic [OW-1:0]       a,
    input  logic [OW-1:0]       b,
    output logic [OW-1:0]       res,
    output logic                ovf
);

    // Wide enough to hold acc + full product exactly, whichever is larger, plus a carry.
    localparam int EW = ((ACC_W > 2 * OW) ? ACC_W : 2 * OW) + 1;

    localparam logic [OW-1:0]    MAX_OW  = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]    MIN_OW  = {1'b1, {(OW-1){1'b0}}};
    localparam logic [ACC_W-1:0] MAX_ACC = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_ACC = {1'b1, {(ACC_W-1){1'b0}}};

    logic [OW-1:0]    res_q, res_d, calc_res;
    logic             ovf_q, ovf_d, calc_ovf;
    logic [ACC_W-1:0] acc_q, acc_d, acc_next;
    logic [OW:0]      sum;
    logic [2*OW-1:0]  prod;
    logic [EW-1:0]    mac_exact;
    logic             mul_ovf, mac_ovf;

    always_comb begin
        // One extra bit makes the add/sub exact; overflow is the top two bits disagreeing.
        if (op == OP_SUB) begin
            sum = {a[OW-1], a} - {b[OW-1], b};
        end else begin
            sum = {a[OW-1], a} + {b[OW-1], b};
        end

        // Sign-extended operands give the exact signed product in 2*OW bits.
        prod = {{OW{a[OW-1]}}, a} * {{OW{b[OW-1]}}, b};
        // Product fits OW bits only if bits [2*OW-1:OW-1] are all copies of the sign.
        mul_ovf = !((&prod[2*OW-1:OW-1]) || !(|prod[2*OW-1:OW-1]));

        mac_exact = {{(EW-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                  + {{(EW-2*OW){prod[2*OW-1]}}, prod};
        mac_ovf   = !((&mac_exact[EW-1:ACC_W-1]) || !(|mac_exact[EW-1:ACC_W-1]));

        acc_next = mac_exact[ACC_W-1:0];
`ifdef SIMD_ALU_SAT_EN
        if (mac_ovf) begin
            acc_next = mac_exact[EW-1] ? MIN_ACC : MAX_ACC;
        end
`endif

        calc_res = '0;
        calc_ovf = 1'b0;
        acc_d    = acc_q;
        case (op)
            OP_ADD, OP_SUB: begin
                calc_ovf = sum[OW] ^ sum[OW-1];
                calc_res = sum[OW-1:0];
`ifdef SIMD_ALU_SAT_EN
                if (calc_ovf) calc_res = sum[OW] ? MIN_OW : MAX_OW;
`endif
            end
            OP_MUL: begin
                calc_ovf = mul_ovf;
                calc_res = prod[OW-1:0];
`ifdef SIMD_ALU_SAT_EN
                if (calc_ovf) calc_res = prod[2*OW-1] ? MIN_OW : MAX_OW;
`endif
            end
            OP_MULH: begin
                calc_res = prod[2*OW-1:OW];
            end
            OP_MAC: begin
                calc_ovf = mac_ovf;
                acc_d    = acc_next;
                calc_res = acc_next[OW-1:0];
            end
            OP_ACC_CLR: begin
                calc_res = acc_q[OW-1:0];
                acc_d    = '0;
            end
            default: begin
            end
        endcase

        // The accumulator only moves on the edge the beat enters S2, never while stalled.
        if (!en) begin
            acc_d = acc_q;
        end
        res_d = en ? calc_res : res_q;
        ovf_d = en ? calc_ovf : ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            acc_q <= '0;
        end else begin
            res_q <= res_d;
            ovf_q <= ovf_d;
            acc_q <= acc_d;
        end
    end

    assign res = res_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD ALU: S1 registers opcode/operands, S2 (one simd_lane per lane) computes.
// Latency: a beat presented in cycle c is captured at the next edge and is on o_res after the following edge.
// Backpressure: S2 holds while o_valid && !i_ready; o_ready is combinational from i_ready (no skid).
//
// Ports: i_clk, i_rst_n (async active-low); input beat i_valid/o_ready/i_opcode/i_in1/i_in2;
// output beat o_valid/i_ready/o_res/o_ovf. Lane k occupies bits [(k+1)*OW-1:k*OW].
// Build option: SIMD_ALU_SAT_EN selects saturating arithmetic inside the lanes.
module simd_alu_pipe
    import simd_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OW    = 32,
    parameter int ACC_W = 2 * OW
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [OPCODE_W-1:0]   i_opcode,
    input  logic [LANES*OW-1:0]   i_in1,
    input  logic [LANES*OW-1:0]   i_in2,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [LANES*OW-1:0]   o_res,
    output logic [LANES-1:0]      o_ovf
);

    logic                s1_valid_q, s1_valid_d;
    logic                s2_valid_q, s2_valid_d;
    logic [OPCODE_W-1:0] s1_op_q, s1_op_d;
    logic [LANES*OW-1:0] s1_a_q, s1_a_d;
    logic [LANES*OW-1:0] s1_b_q, s1_b_d;
    logic                s1_advance, in_fire;
    logic [OW-1:0]       lane_res [LANES];
    logic [LANES-1:0]    lane_ovf;

    always_comb begin
        // S2 can take a new beat when it is empty or its current beat leaves this edge.
        s1_advance = s1_valid_q && (!s2_valid_q || i_ready);
        o_ready    = !s1_valid_q || s1_advance;
        in_fire    = i_valid && o_ready;

        s1_valid_d = in_fire ? 1'b1 : (s1_advance ? 1'b0 : s1_valid_q);
        s2_valid_d = s1_advance || (s2_valid_q && !i_ready);

        s1_op_d = in_fire ? i_opcode : s1_op_q;
        s1_a_d  = in_fire ? i_in1    : s1_a_q;
        s1_b_d  = in_fire ? i_in2    : s1_b_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Operand/opcode registers are qualified by s1_valid_q, so they carry no reset.
    always_ff @(posedge i_clk) begin
        s1_op_q <= s1_op_d;
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        simd_lane #(
            .OW    (OW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .en    (s1_advance),
            .op    (s1_op_q),
            .a     (s1_a_q[lane_lsb(k, OW) +: OW]),
            .b     (s1_b_q[lane_lsb(k, OW) +: OW]),
            .res   (lane_res[k]),
            .ovf   (lane_ovf[k])
        );
    end

    always_comb begin
        o_res = '0;
        for (int k = 0; k < LANES; k++) begin
            o_res[lane_lsb(k, OW) +: OW] = lane_res[k];
        end
    end

    assign o_ovf   = lane_ovf;
    assign o_valid = s2_valid_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Bench for simd_alu_pipe (LANES=4, OW=32, ACC_W=64): directed vectors with literal
// expectations plus a per-beat arithmetic model checked on every output handshake.
module tb_simd_alu_pipe;

    localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_MUL = 3'd2, C_MULH = 3'd3;
    localparam logic [2:0] C_MAC = 3'd4, C_CLR = 3'd5, C_RSV = 3'd6;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 1;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [2:0]   i_opcode = '0;
    logic [127:0] i_in1 = '0;
    logic [127:0] i_in2 = '0;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic [127:0] o_res;
    logic [3:0]   o_ovf;

    int total = 0;
    int bad   = 0;

    logic [127:0]       exp_res[$];
    logic [3:0]         exp_ovf[$];
    logic [127:0]       got_res[$];
    logic [3:0]         got_ovf[$];
    logic signed [63:0] macc [4];
    logic               prev_stall = 1'b0;
    logic [127:0]       prev_res;
    logic [3:0]         prev_ovf;
    logic               saw_block = 1'b0;

    simd_alu_pipe #(.LANES(4), .OW(32), .ACC_W(64)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_opcode (i_opcode),
        .i_in1    (i_in1),
        .i_in2    (i_in2),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_res    (o_res),
        .o_ovf    (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Arithmetic reference for one lane, from the signed-value definitions of each op.
    function automatic void mlane(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic signed [63:0] acc, output logic [31:0] r, output logic o);
        longint sa, sb, ex;
        logic signed [127:0] big, hi, lo;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        hi = 128'sd9223372036854775807;
        lo = -hi - 128'sd1;
        r = '0;
        o = 1'b0;
        case (op)
            C_ADD, C_SUB, C_MUL: begin
                ex = (op == C_ADD) ? sa + sb : (op == C_SUB) ? sa - sb : sa * sb;
                o  = (ex > MAXV) || (ex < MINV);
                r  = ex[31:0];
`ifdef SIMD_ALU_SAT_EN
                if (o) r = (ex < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
            end
            C_MULH: begin
                ex = sa * sb;
                r  = ex[63:32];
            end
            C_MAC: begin
                big = 128'(acc) + 128'(sa * sb);
                o   = (big > hi) || (big < lo);
                acc = big[63:0];
`ifdef SIMD_ALU_SAT_EN
                if (o) acc = (big < 0) ? 64'sh8000_0000_0000_0000 : 64'sh7FFF_FFFF_FFFF_FFFF;
`endif
                r = acc[31:0];
            end
            C_CLR: begin
                r   = acc[31:0];
                acc = '0;
            end
            default: begin
            end
        endcase
    endfunction

    // Compare process: model updated on every accepted beat, checked on every delivered beat.
    always @(negedge i_clk) begin
        logic [127:0] er;
        logic [3:0]   eo;
        logic [31:0]  r;
        logic         o;
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", o_valid, 1);
                check("hold_res", o_res, prev_res);
                check("hold_ovf", o_ovf, prev_ovf);
            end
            if (o_valid && i_ready) begin
                if (exp_res.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h expected no beat", o_res);
                end else begin
                    er = exp_res.pop_front();
                    eo = exp_ovf.pop_front();
                    check("mon_res", o_res, er);
                    check("mon_ovf", o_ovf, eo);
                end
                got_res.push_back(o_res);
                got_ovf.push_back(o_ovf);
            end
            if (i_valid && o_ready) begin
                er = '0;
                eo = '0;
                for (int k = 0; k < 4; k++) begin
                    mlane(i_opcode, i_in1[k*32 +: 32], i_in2[k*32 +: 32], macc[k], r, o);
                    er[k*32 +: 32] = r;
                    eo[k] = o;
                end
                exp_res.push_back(er);
                exp_ovf.push_back(eo);
            end
            if (i_valid && !o_ready) saw_block = 1'b1;
            prev_stall = o_valid && !i_ready;
            prev_res   = o_res;
            prev_ovf   = o_ovf;
        end
    end

    task automatic sync();
        @(posedge i_clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted (bounded).
    task automatic send(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b);
        int n;
        n = 0;
        i_valid  = 1'b1;
        i_opcode = op;
        i_in1    = a;
        i_in2    = b;
        forever begin
            @(negedge i_clk);
            if (o_ready) begin
                @(posedge i_clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: o_ready stayed %b, required 1", o_ready);
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input string nm);
        int c;
        c = 0;
        while (got_res.size() < n && c < 200) begin
            sync();
            c++;
        end
        check(nm, got_res.size(), n);
    endtask

    function automatic logic [127:0] got_at(input int idx);
        if (idx < got_res.size()) return got_res[idx];
        return 'x;
    endfunction

    function automatic logic [3:0] ovf_at(input int idx);
        if (idx < got_ovf.size()) return got_ovf[idx];
        return 'x;
    endfunction

    function automatic logic [31:0] lane0_at(input int idx);
        logic [127:0] v;
        v = got_at(idx);
        return v[31:0];
    endfunction

    initial begin
        int nb;
        logic [31:0] sat_a, sat_s, sat_m0, sat_m2, sat_mac;
`ifdef SIMD_ALU_SAT_EN
        sat_a = 32'h7FFF_FFFF; sat_s = 32'h8000_0000; sat_m0 = 32'h7FFF_FFFF;
        sat_m2 = 32'h7FFF_FFFF; sat_mac = 32'hFFFF_FFFF;
`else
        sat_a = 32'h8000_0000; sat_s = 32'h7FFF_FFFF; sat_m0 = 32'h0;
        sat_m2 = 32'hFFFF_FFFE; sat_mac = 32'h0;
`endif
        for (int k = 0; k < 4; k++) macc[k] = '0;

        // Reset state
        #12;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_ready", o_ready, 1);
        check("rst_o_res", o_res, 0);
        check("rst_o_ovf", o_ovf, 0);
        sync();
        i_rst_n = 1'b1;
        sync();

        // ADD with lane-2 overflow; also pins the two-edge latency
        send(C_ADD, pk(32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5),
                    pk(32'd2, 32'd1, 32'd1, 32'hFFFF_FFF9));
        @(negedge i_clk);
        check("lat_after_1_edge", o_valid, 0);
        @(negedge i_clk);
        check("lat_after_2_edges", o_valid, 1);
        wait_out(1, "add_count");
        check("add_res", got_at(0), pk(32'd3, 32'd0, sat_a, 32'hFFFF_FFFE));
        check("add_ovf", ovf_at(0), 4'b0100);

        // SUB, MUL, MULH, reserved streamed back to back
        send(C_SUB, pk(32'd5, 32'h8000_0000, 32'd0, 32'd10), pk(32'd3, 32'd1, 32'd1, 32'hFFFF_FFFE));
        send(C_MUL, pk(32'h1_0000, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'd0), pk(32'h1_0000, 32'd4, 32'd2, 32'd5));
        send(C_MULH, pk(32'h1_0000, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'd0), pk(32'h1_0000, 32'd4, 32'd2, 32'd5));
        send(C_RSV, pk(32'd9, 32'd9, 32'd9, 32'd9), pk(32'd9, 32'd9, 32'd9, 32'd9));
        wait_out(5, "alu_count");
        check("sub_res", got_at(1), pk(32'd2, sat_s, 32'hFFFF_FFFF, 32'd12));
        check("sub_ovf", ovf_at(1), 4'b0010);
        check("mul_res", got_at(2), pk(sat_m0, 32'hFFFF_FFF4, sat_m2, 32'd0));
        check("mul_ovf", ovf_at(2), 4'b0101);
        check("mulh_res", got_at(3), pk(32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0));
        check("mulh_ovf", ovf_at(3), 4'b0000);
        check("rsv_res", got_at(4), 128'd0);

        // Back-to-back MAC chain, clear, restart
        send(C_MAC, pk(32'd2, 0, 0, 0), pk(32'd3, 0, 0, 0));
        send(C_MAC, pk(32'd4, 0, 0, 0), pk(32'd5, 0, 0, 0));
        send(C_MAC, pk(32'hFFFF_FFFF, 0, 0, 0), pk(32'd6, 0, 0, 0));
        send(C_CLR, '0, '0);
        send(C_MAC, pk(32'd1, 0, 0, 0), pk(32'd1, 0, 0, 0));
        wait_out(10, "mac_count");
        check("mac1", lane0_at(5), 32'd6);
        check("mac2", lane0_at(6), 32'd26);
        check("mac3", lane0_at(7), 32'd20);
        check("mac_clr", lane0_at(8), 32'd20);
        check("mac_after_clr", lane0_at(9), 32'd1);

        // Backpressure: 6 beats, i_ready low for cycles 3-6
        nb = got_res.size();
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(C_ADD, {4{32'(i * 16)}}, pk(32'd100, 32'd200, 32'd300, 32'd400));
            end
            begin
                for (int c = 1; c <= 8; c++) begin
                    @(posedge i_clk);
                    #1;
                    i_ready = !(c >= 3 && c <= 6);
                end
            end
        join
        i_ready = 1'b1;
        wait_out(nb + 6, "bp_count");
        repeat (4) sync();
        check("bp_no_dup", got_res.size(), nb + 6);
        check("bp_oready_drop", saw_block, 1);
        check("bp_last", got_at(nb + 5), pk(32'd180, 32'd280, 32'd380, 32'd480));

        // MAC held in S1 for 3 cycles must accumulate once
        send(C_CLR, '0, '0);
        wait_out(nb + 7, "stall_clr_count");
        i_ready = 1'b0;
        send(C_ADD, pk(32'd1, 0, 0, 0), pk(32'd1, 0, 0, 0));
        send(C_MAC, pk(32'd3, 0, 0, 0), pk(32'd7, 0, 0, 0));
        repeat (3) sync();
        check("stall_oready", o_ready, 0);
        i_ready = 1'b1;
        send(C_MAC, pk(32'd1, 0, 0, 0), pk(32'd1, 0, 0, 0));
        wait_out(nb + 10, "stall_count");
        check("stall_mac", lane0_at(nb + 8), 32'd21);
        check("stall_mac_next", lane0_at(nb + 9), 32'd22);

        // Accumulator overflow: two MACs of (-2^31)^2 reach 2^63
        nb = got_res.size();
        send(C_CLR, '0, '0);
        send(C_MAC, {4{32'h8000_0000}}, {4{32'h8000_0000}});
        send(C_MAC, {4{32'h8000_0000}}, {4{32'h8000_0000}});
        send(C_CLR, '0, '0);
        wait_out(nb + 4, "macovf_count");
        check("macovf_first", ovf_at(nb + 1), 4'b0000);
        check("macovf_second", ovf_at(nb + 2), 4'b1111);
        check("macovf_res", lane0_at(nb + 2), sat_mac);
        check("macovf_clr", lane0_at(nb + 3), sat_mac);

        // Asynchronous reset mid-stream with acc=26
        nb = got_res.size();
        send(C_MAC, pk(32'd2, 0, 0, 0), pk(32'd3, 0, 0, 0));
        send(C_MAC, pk(32'd4, 0, 0, 0), pk(32'd5, 0, 0, 0));
        wait_out(nb + 2, "rstmid_pre_count");
        check("rstmid_acc", lane0_at(nb + 1), 32'd26);
        i_ready = 1'b0;
        send(C_ADD, pk(32'd7, 0, 0, 0), pk(32'd7, 0, 0, 0));
        send(C_ADD, pk(32'd8, 0, 0, 0), pk(32'd8, 0, 0, 0));
        #2;
        i_rst_n = 1'b0;
        exp_res.delete();
        exp_ovf.delete();
        for (int k = 0; k < 4; k++) macc[k] = '0;
        #1;
        check("rstmid_o_valid", o_valid, 0);
        check("rstmid_o_ready", o_ready, 1);
        check("rstmid_o_res", o_res, 0);
        repeat (2) sync();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        sync();
        nb = got_res.size();
        send(C_MAC, pk(32'd1, 0, 0, 0), pk(32'd1, 0, 0, 0));
        wait_out(nb + 1, "rstmid_post_count");
        check("rstmid_mac", lane0_at(nb), 32'd1);
        repeat (5) sync();
        check("rstmid_no_stale", got_res.size(), nb + 1);
        check("model_drained", exp_res.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
